// File: rtl/ctrl_mseq.sv
// ctrl_mseq: registered RV32IM control decode with a multi-cycle M-extension sequencer.
// Define CTRL_MSEQ_PERF_EN to add the saturating op_stall_cnt performance counter.
module ctrl_mseq #(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        ip_clk,
  input  logic        ip_rst,
  input  logic        ip_valid,
  input  logic [6:0]  ip_opcode,
  input  logic [2:0]  ip_funct_3,
  input  logic [6:0]  ip_funct_7,
  input  logic        ip_flush,
`ifdef CTRL_MSEQ_PERF_EN
  output logic [15:0] op_stall_cnt,
`endif
  output logic        op_ready,
  output logic        op_stall,
  output logic        op_valid,
  output logic        op_illegal,
  output logic        op_reg_wr_en,
  output logic        op_store_en,
  output logic        op_jump_ctrl,
  output logic [2:0]  op_imm_ext_ctrl,
  output logic [2:0]  op_ALU_operation_ctrl,
  output logic [2:0]  op_ALU_branch_ctrl,
  output logic [1:0]  op_load_store_bit_ctrl,
  output logic        op_load_sign_ctrl,
  output logic        op_m_ext_start,
  output logic        op_m_ext_wb_ctrl
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_M   = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [2:0] BR_NONE = 3'b010;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MBUSY = 2'd1,
    S_MDONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       valid_q, valid_d;
  logic       illegal_q, illegal_d;
  logic       reg_wr_en_q, reg_wr_en_d;
  logic       store_en_q, store_en_d;
  logic       jump_q, jump_d;
  logic [2:0] imm_q, imm_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [2:0] branch_q, branch_d;
  logic [1:0] ls_bit_q, ls_bit_d;
  logic       load_sign_q, load_sign_d;
  logic       m_start_q, m_start_d;
  logic       m_wb_q, m_wb_d;

  logic       dec_illegal;
  logic       dec_reg_wr_en;
  logic       dec_store_en;
  logic       dec_jump;
  logic [2:0] dec_imm;
  logic [2:0] dec_alu_op;
  logic [2:0] dec_branch;
  logic [1:0] dec_ls_bit;
  logic       dec_load_sign;

  logic       is_m_op;
  logic       accept;

  assign op_ready = (state_q != S_MBUSY);
  assign op_stall = (state_q == S_MBUSY);
  assign is_m_op  = (ip_opcode == OPC_OP) && (ip_funct_7 == FUNCT7_M);
  assign accept   = ip_valid && op_ready && !ip_flush;

  // Plain RV32I field decode; anything outside the table is reported illegal.
  always_comb begin
    dec_illegal   = 1'b0;
    dec_reg_wr_en = 1'b0;
    dec_store_en  = 1'b0;
    dec_jump      = 1'b0;
    dec_imm       = IMM_I;
    dec_alu_op    = 3'b000;
    dec_branch    = BR_NONE;
    dec_ls_bit    = 2'b00;
    dec_load_sign = 1'b0;
    unique case (ip_opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_reg_wr_en = 1'b1;
        dec_imm       = IMM_U;
      end
      OPC_JAL: begin
        dec_reg_wr_en = 1'b1;
        dec_jump      = 1'b1;
        dec_imm       = IMM_J;
      end
      OPC_JALR: begin
        dec_reg_wr_en = 1'b1;
        dec_jump      = 1'b1;
        dec_imm       = IMM_I;
      end
      OPC_BRANCH: begin
        dec_imm    = IMM_B;
        dec_branch = ip_funct_3;
      end
      OPC_LOAD: begin
        dec_reg_wr_en = 1'b1;
        dec_imm       = IMM_I;
        dec_ls_bit    = ip_funct_3[1:0];
        dec_load_sign = ~ip_funct_3[2];
      end
      OPC_STORE: begin
        dec_store_en = 1'b1;
        dec_imm      = IMM_S;
        dec_ls_bit   = ip_funct_3[1:0];
      end
      OPC_OP_IMM, OPC_OP: begin
        dec_reg_wr_en = 1'b1;
        dec_imm       = IMM_I;
        dec_alu_op    = ip_funct_3;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Sequencer: flush dominates everything, MBUSY ignores new work until the counter drains.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    illegal_d   = 1'b0;
    reg_wr_en_d = 1'b0;
    store_en_d  = 1'b0;
    jump_d      = 1'b0;
    imm_d       = IMM_I;
    alu_op_d    = 3'b000;
    branch_d    = BR_NONE;
    ls_bit_d    = 2'b00;
    load_sign_d = 1'b0;
    m_start_d   = 1'b0;
    m_wb_d      = 1'b0;
    if (ip_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_MBUSY: begin
          if (cnt_q == '0) begin
            state_d     = S_MDONE;
            valid_d     = 1'b1;
            reg_wr_en_d = 1'b1;
            m_wb_d      = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_IDLE, S_MDONE: begin
          state_d = S_IDLE;
          if (accept && is_m_op) begin
            state_d   = S_MBUSY;
            cnt_d     = ip_funct_3[2] ? DIV_LOAD : MUL_LOAD;
            m_start_d = 1'b1;
          end else if (accept) begin
            valid_d     = 1'b1;
            illegal_d   = dec_illegal;
            reg_wr_en_d = dec_reg_wr_en;
            store_en_d  = dec_store_en;
            jump_d      = dec_jump;
            imm_d       = dec_imm;
            alu_op_d    = dec_alu_op;
            branch_d    = dec_branch;
            ls_bit_d    = dec_ls_bit;
            load_sign_d = dec_load_sign;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      illegal_q   <= 1'b0;
      reg_wr_en_q <= 1'b0;
      store_en_q  <= 1'b0;
      jump_q      <= 1'b0;
      imm_q       <= IMM_I;
      alu_op_q    <= 3'b000;
      branch_q    <= BR_NONE;
      ls_bit_q    <= 2'b00;
      load_sign_q <= 1'b0;
      m_start_q   <= 1'b0;
      m_wb_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      illegal_q   <= illegal_d;
      reg_wr_en_q <= reg_wr_en_d;
      store_en_q  <= store_en_d;
      jump_q      <= jump_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      branch_q    <= branch_d;
      ls_bit_q    <= ls_bit_d;
      load_sign_q <= load_sign_d;
      m_start_q   <= m_start_d;
      m_wb_q      <= m_wb_d;
    end
  end

  assign op_valid               = valid_q;
  assign op_illegal             = illegal_q;
  assign op_reg_wr_en           = reg_wr_en_q;
  assign op_store_en            = store_en_q;
  assign op_jump_ctrl           = jump_q;
  assign op_imm_ext_ctrl        = imm_q;
  assign op_ALU_operation_ctrl  = alu_op_q;
  assign op_ALU_branch_ctrl     = branch_q;
  assign op_load_store_bit_ctrl = ls_bit_q;
  assign op_load_sign_ctrl      = load_sign_q;
  assign op_m_ext_start         = m_start_q;
  assign op_m_ext_wb_ctrl       = m_wb_q;

`ifdef CTRL_MSEQ_PERF_EN
  // Counts stalled cycles since reset; flush deliberately leaves it alone.
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (op_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign op_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_mseq.sv
// tb_ctrl_mseq: directed and randomized checking of ctrl_mseq against a cycle-indexed
// schedule of expected control bundles derived from the decode and M-unit timing rules.
module tb_ctrl_mseq;

  localparam int MUL_N = 1;
  localparam int DIV_N = 32;

  logic        ip_clk;
  logic        ip_rst;
  logic        ip_valid;
  logic [6:0]  ip_opcode;
  logic [2:0]  ip_funct_3;
  logic [6:0]  ip_funct_7;
  logic        ip_flush;
  logic        op_ready;
  logic        op_stall;
  logic        op_valid;
  logic        op_illegal;
  logic        op_reg_wr_en;
  logic        op_store_en;
  logic        op_jump_ctrl;
  logic [2:0]  op_imm_ext_ctrl;
  logic [2:0]  op_ALU_operation_ctrl;
  logic [2:0]  op_ALU_branch_ctrl;
  logic [1:0]  op_load_store_bit_ctrl;
  logic        op_load_sign_ctrl;
  logic        op_m_ext_start;
  logic        op_m_ext_wb_ctrl;
`ifdef CTRL_MSEQ_PERF_EN
  logic [15:0] op_stall_cnt;
`endif

  ctrl_mseq #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .CNT_W(6)
  ) dut (
    .ip_clk(ip_clk),
    .ip_rst(ip_rst),
    .ip_valid(ip_valid),
    .ip_opcode(ip_opcode),
    .ip_funct_3(ip_funct_3),
    .ip_funct_7(ip_funct_7),
    .ip_flush(ip_flush),
`ifdef CTRL_MSEQ_PERF_EN
    .op_stall_cnt(op_stall_cnt),
`endif
    .op_ready(op_ready),
    .op_stall(op_stall),
    .op_valid(op_valid),
    .op_illegal(op_illegal),
    .op_reg_wr_en(op_reg_wr_en),
    .op_store_en(op_store_en),
    .op_jump_ctrl(op_jump_ctrl),
    .op_imm_ext_ctrl(op_imm_ext_ctrl),
    .op_ALU_operation_ctrl(op_ALU_operation_ctrl),
    .op_ALU_branch_ctrl(op_ALU_branch_ctrl),
    .op_load_store_bit_ctrl(op_load_store_bit_ctrl),
    .op_load_sign_ctrl(op_load_sign_ctrl),
    .op_m_ext_start(op_m_ext_start),
    .op_m_ext_wb_ctrl(op_m_ext_wb_ctrl)
  );

  initial ip_clk = 1'b0;
  always #5 ip_clk = ~ip_clk;

  typedef struct packed {
    logic       has;
    logic       full;
    logic       valid;
    logic       illegal;
    logic       reg_wr;
    logic       store;
    logic       jump;
    logic [2:0] imm;
    logic [2:0] alu;
    logic [2:0] branch;
    logic [1:0] ls;
    logic       sign;
    logic       start;
    logic       wb;
  } exp_t;

  // Expected outputs keyed by cycle number (mod 64; nothing is scheduled further than DIV_N+1 ahead).
  exp_t        sched [64];
  int          cyc;
  int          stall_lo;
  int          stall_hi;
  logic        model_known;
  logic [15:0] perf_model;
  int          n_cmp;
  int          n_fail;

  logic [6:0]  legal_opc [9];
  logic [6:0]  bad_opc [4];

  function automatic exp_t modelDecode(input logic [6:0] opc, input logic [2:0] f3);
    exp_t e;
    e        = '0;
    e.has    = 1'b1;
    e.full   = 1'b1;
    e.valid  = 1'b1;
    e.branch = 3'b010;
    case (opc)
      7'b0110111, 7'b0010111: begin e.reg_wr = 1'b1; e.imm = 3'd3; end
      7'b1101111: begin e.reg_wr = 1'b1; e.jump = 1'b1; e.imm = 3'd4; end
      7'b1100111: begin e.reg_wr = 1'b1; e.jump = 1'b1; e.imm = 3'd0; end
      7'b1100011: begin e.imm = 3'd2; e.branch = f3; end
      7'b0000011: begin e.reg_wr = 1'b1; e.ls = f3[1:0]; e.sign = ~f3[2]; end
      7'b0100011: begin e.store = 1'b1; e.imm = 3'd1; e.ls = f3[1:0]; end
      7'b0010011, 7'b0110011: begin e.reg_wr = 1'b1; e.alu = f3; end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compares the DUT against the scheduled expectation for the current cycle.
  task automatic checkOutput();
    exp_t e;
    logic exp_stall;
    if (!model_known) return;
    e = sched[cyc % 64];
    sched[cyc % 64] = '0;
    exp_stall = (cyc >= stall_lo) && (cyc <= stall_hi);
    checkField("ready", op_ready, !exp_stall);
    checkField("stall", op_stall, exp_stall);
    checkField("valid", op_valid, e.valid);
    checkField("reg_wr_en", op_reg_wr_en, e.reg_wr);
    checkField("store_en", op_store_en, e.store);
    checkField("jump_ctrl", op_jump_ctrl, e.jump);
    checkField("m_ext_start", op_m_ext_start, e.start);
    checkField("m_ext_wb_ctrl", op_m_ext_wb_ctrl, e.wb);
    if (e.valid) checkField("illegal", op_illegal, e.illegal);
    if (e.full) begin
      checkField("imm_ext_ctrl", op_imm_ext_ctrl, e.imm);
      checkField("alu_op_ctrl", op_ALU_operation_ctrl, e.alu);
      checkField("alu_branch_ctrl", op_ALU_branch_ctrl, e.branch);
      checkField("ls_bit_ctrl", op_load_store_bit_ctrl, e.ls);
      checkField("load_sign_ctrl", op_load_sign_ctrl, e.sign);
    end
`ifdef CTRL_MSEQ_PERF_EN
    checkField("stall_cnt", op_stall_cnt, perf_model);
`endif
  endtask

  // Checks the current cycle, drives one cycle of inputs, and schedules what they must cause.
  task automatic applyStimulus(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input logic fl, input logic rs);
    exp_t e;
    logic stall_now;
    logic is_m;
    int   n;
    checkOutput();
    ip_valid   = v;
    ip_opcode  = opc;
    ip_funct_3 = f3;
    ip_funct_7 = f7;
    ip_flush   = fl;
    ip_rst     = rs;
    stall_now  = (cyc >= stall_lo) && (cyc <= stall_hi);
    is_m       = (opc == 7'b0110011) && (f7 == 7'b0000001);
    if (rs) begin
      for (int j = 0; j < 64; j++) sched[j] = '0;
      stall_lo    = 0;
      stall_hi    = -1;
      perf_model  = 16'd0;
      model_known = 1'b1;
    end else if (model_known) begin
      if (stall_now && perf_model != 16'hFFFF) perf_model++;
      if (fl) begin
        for (int j = 0; j < 64; j++) sched[j] = '0;
        if (stall_hi > cyc) stall_hi = cyc;
      end else if (v && !stall_now) begin
        if (is_m) begin
          n = f3[2] ? DIV_N : MUL_N;
          e = '0; e.has = 1'b1; e.start = 1'b1;
          sched[(cyc + 1) % 64] = e;
          stall_lo = cyc + 1;
          stall_hi = cyc + n;
          e = '0; e.has = 1'b1; e.valid = 1'b1; e.reg_wr = 1'b1; e.wb = 1'b1;
          sched[(cyc + 1 + n) % 64] = e;
        end else begin
          sched[(cyc + 1) % 64] = modelDecode(opc, f3);
        end
      end
    end
    @(posedge ip_clk);
    cyc++;
    @(negedge ip_clk);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic        v, fl, rs;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    int unsigned kind;

    legal_opc[0] = 7'b0110111; legal_opc[1] = 7'b0010111; legal_opc[2] = 7'b1101111;
    legal_opc[3] = 7'b1100111; legal_opc[4] = 7'b1100011; legal_opc[5] = 7'b0000011;
    legal_opc[6] = 7'b0100011; legal_opc[7] = 7'b0010011; legal_opc[8] = 7'b0110011;
    bad_opc[0] = 7'b1111111; bad_opc[1] = 7'b0000000;
    bad_opc[2] = 7'b1011011; bad_opc[3] = 7'b0101011;

    for (int j = 0; j < 64; j++) sched[j] = '0;
    cyc = 0; stall_lo = 0; stall_hi = -1; model_known = 1'b0; perf_model = 16'd0;
    n_cmp = 0; n_fail = 0;
    ip_rst = 1'b1; ip_valid = 1'b0; ip_opcode = 7'd0; ip_funct_3 = 3'd0;
    ip_funct_7 = 7'd0; ip_flush = 1'b0;

    resetDut();
    checkField("rst_valid", op_valid, 1'b0);
    checkField("rst_branch", op_ALU_branch_ctrl, 3'b010);
    checkField("rst_ready", op_ready, 1'b1);
    checkField("rst_stall", op_stall, 1'b0);

    applyStimulus(1'b1, 7'b0010011, 3'b000, 7'd0, 1'b0, 1'b0);
    checkField("addi_valid", op_valid, 1'b1);
    checkField("addi_wr", op_reg_wr_en, 1'b1);
    checkField("addi_imm", op_imm_ext_ctrl, 3'd0);
    checkField("addi_alu", op_ALU_operation_ctrl, 3'b000);

    applyStimulus(1'b1, 7'b1100011, 3'b111, 7'd0, 1'b0, 1'b0);
    checkField("bgeu_branch", op_ALU_branch_ctrl, 3'b111);
    checkField("bgeu_imm", op_imm_ext_ctrl, 3'd2);
    checkField("bgeu_wr", op_reg_wr_en, 1'b0);

    applyStimulus(1'b1, 7'b0110011, 3'b000, 7'b0000001, 1'b0, 1'b0);
    checkField("mul_start", op_m_ext_start, 1'b1);
    checkField("mul_stall", op_stall, 1'b1);
    checkField("mul_start_valid", op_valid, 1'b0);
    applyStimulus(1'b1, 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
    checkField("mul_result_valid", op_valid, 1'b1);
    checkField("mul_result_wb", op_m_ext_wb_ctrl, 1'b1);
    checkField("mul_result_ready", op_ready, 1'b1);
    applyStimulus(1'b1, 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
    checkField("add_b2b_valid", op_valid, 1'b1);
    checkField("add_b2b_wb", op_m_ext_wb_ctrl, 1'b0);
    checkField("add_b2b_wr", op_reg_wr_en, 1'b1);

    resetDut();
    applyStimulus(1'b1, 7'b0110011, 3'b100, 7'b0000001, 1'b0, 1'b0);
    checkField("div_stall", op_stall, 1'b1);
    idleCycles(9);
    applyStimulus(1'b1, 7'b0010011, 3'b000, 7'd0, 1'b1, 1'b0);
    checkField("flush_stall", op_stall, 1'b0);
    checkField("flush_ready", op_ready, 1'b1);
    checkField("flush_valid", op_valid, 1'b0);
`ifdef CTRL_MSEQ_PERF_EN
    checkField("flush_stall_cnt", op_stall_cnt, 16'd10);
`endif
    idleCycles(36);

    applyStimulus(1'b1, 7'b1111111, 3'b000, 7'd0, 1'b0, 1'b0);
    checkField("ill_valid", op_valid, 1'b1);
    checkField("ill_flag", op_illegal, 1'b1);
    checkField("ill_wr", op_reg_wr_en, 1'b0);
    checkField("ill_store", op_store_en, 1'b0);
    checkField("ill_jump", op_jump_ctrl, 1'b0);

    applyStimulus(1'b1, 7'b0110011, 3'b110, 7'b0000001, 1'b0, 1'b0);
    idleCycles(31);
    checkField("div_last_stall", op_stall, 1'b1);
    idleCycles(1);
    checkField("div_done_valid", op_valid, 1'b1);
    checkField("div_done_wb", op_m_ext_wb_ctrl, 1'b1);

    applyStimulus(1'b1, 7'b0110011, 3'b101, 7'b0000001, 1'b0, 1'b0);
    idleCycles(4);
    applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b1);
    checkField("rst_mid_busy_stall", op_stall, 1'b0);
    idleCycles(36);

    for (int i = 0; i < 2500; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 99) < 4);
      rs   = ($urandom_range(0, 299) == 0);
      f3   = 3'($urandom_range(0, 7));
      f7   = 7'($urandom_range(0, 127));
      kind = $urandom_range(0, 15);
      if (kind < 3) begin
        opc = 7'b0110011;
        f7  = 7'b0000001;
      end else if (kind < 13) begin
        opc = legal_opc[$urandom_range(0, 8)];
      end else begin
        opc = bad_opc[$urandom_range(0, 3)];
      end
      applyStimulus(v, opc, f3, f7, fl, rs);
    end
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
